// File: rtl/opacc_pkg.sv
// Shared types and default geometry for the opacc outer-product accumulator
// and its command sequencer.
package opacc_pkg;

  localparam int NREGS_DEF = 2;
  localparam int VL_DEF    = 4;
  localparam int ML_DEF    = 4;
  localparam int XLEN_DEF  = 64;
  localparam int KW_DEF    = 16;

  typedef enum logic {
    OP_SWAP = 1'b0,
    OP_MAC  = 1'b1
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SWAP = 2'd1,
    S_MAC  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef logic [XLEN_DEF-1:0]        elem_t;
  typedef logic [VL_DEF*XLEN_DEF-1:0] row_t;
  typedef logic [ML_DEF*XLEN_DEF-1:0] col_t;

  // A single tile register still needs a one-bit address bus.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/opacc_ctrl.sv
// Command sequencer for opacc: swaps C-tile rows in/out and streams A/B operand
// pairs, owning every opacc strobe and address.
module opacc_ctrl
  import opacc_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int VL    = VL_DEF,
  parameter int ML    = ML_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int KW    = KW_DEF,
  localparam int AW   = addr_width(NREGS),
  localparam int BW   = $clog2(ML) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [AW-1:0]        cmd_reg,
  input  logic [KW-1:0]        cmd_k,
  input  logic                 cin_valid,
  output logic                 cin_ready,
  input  logic [VL*XLEN-1:0]   cin_row,
  output logic                 cout_valid,
  input  logic                 cout_ready,
  output logic [VL*XLEN-1:0]   cout_row,
  input  logic                 ab_valid,
  output logic                 ab_ready,
  input  logic [ML*XLEN-1:0]   ab_a,
  input  logic [VL*XLEN-1:0]   ab_b,
  output logic                 done,
  output logic                 op_valid,
  output logic                 a_valid,
  output logic                 b_valid,
  output logic                 c_valid,
  output logic [AW-1:0]        op_addr,
  output logic [AW-1:0]        ab_addr,
  output logic [AW-1:0]        c_addr,
  output logic [ML*XLEN-1:0]   ai,
  output logic [VL*XLEN-1:0]   bi,
  output logic [VL*XLEN-1:0]   ci,
  input  logic [VL*XLEN-1:0]   co
);

  state_e          state_q, state_d;
  logic [AW-1:0]   reg_q, reg_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   acc_q, acc_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            pend_q, pend_d;

  logic            cmd_fire;
  logic            beat_fire;
  logic            ab_fire;
  logic            last_beat;
  logic            all_accepted;

  // A swap beat needs both the incoming and outgoing row at once, so the row
  // handshakes are joint and no half-transferred beat can exist.
  always_comb begin
    cmd_fire     = (state_q == S_IDLE) && cmd_valid;
    beat_fire    = (state_q == S_SWAP) && cin_valid && cout_ready;
    last_beat    = (beat_q == BW'(ML - 1));
    all_accepted = (acc_q == k_q);
    ab_fire      = (state_q == S_MAC) && !all_accepted && ab_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // MAC leaves once every pair is accepted; the last pending op issues in
  // that same final cycle, so DONE never overlaps an op strobe.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          state_d = (cmd_op_e'(cmd_op) == OP_MAC) ? S_MAC : S_SWAP;
        end
      end
      S_SWAP: begin
        if (beat_fire && last_beat) begin
          state_d = S_DONE;
        end
      end
      S_MAC: begin
        if (all_accepted) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q  <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      beat_q <= '0;
      pend_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      k_q    <= k_d;
      acc_q  <= acc_d;
      beat_q <= beat_d;
      pend_q <= pend_d;
    end
  end

  // Command fields are captured only on the accept handshake; the pend flag
  // delays each op by one cycle so the next pair loads while this one issues.
  always_comb begin
    reg_d  = reg_q;
    k_d    = k_q;
    acc_d  = acc_q;
    beat_d = beat_q;
    pend_d = ab_fire;
    if (cmd_fire) begin
      reg_d  = cmd_reg;
      k_d    = cmd_k;
      acc_d  = '0;
      beat_d = '0;
    end
    if (beat_fire) begin
      beat_d = beat_q + BW'(1);
    end
    if (ab_fire) begin
      acc_d = acc_q + KW'(1);
    end
  end

  always_comb begin
    cmd_ready  = 1'b0;
    cin_ready  = 1'b0;
    cout_valid = 1'b0;
    c_valid    = 1'b0;
    ab_ready   = 1'b0;
    a_valid    = 1'b0;
    b_valid    = 1'b0;
    op_valid   = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
      end
      S_SWAP: begin
        cin_ready  = beat_fire;
        cout_valid = beat_fire;
        c_valid    = beat_fire;
      end
      S_MAC: begin
        ab_ready = !all_accepted;
        a_valid  = ab_fire;
        b_valid  = ab_fire;
        op_valid = pend_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  assign op_addr  = reg_q;
  assign ab_addr  = reg_q;
  assign c_addr   = reg_q;
  assign ai       = ab_a;
  assign bi       = ab_b;
  assign ci       = cin_row;
  assign cout_row = co;

endmodule

// File: tb/tb_opacc_ctrl.sv
// Scoreboard bench for opacc_ctrl driving a behavioural opacc tile model;
// stimulus pushes expectations, a negedge monitor pops and compares them.
module tb_opacc_ctrl;
  import opacc_pkg::*;

  localparam int NREGS = 2;
  localparam int VL    = 4;
  localparam int ML    = 4;
  localparam int XLEN  = 64;
  localparam int KW    = 16;
  localparam int AW    = 1;
  localparam int RW    = VL * XLEN;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid, cmd_ready, cmd_op;
  logic [AW-1:0]   cmd_reg;
  logic [KW-1:0]   cmd_k;
  logic            cin_valid, cin_ready;
  logic [RW-1:0]   cin_row;
  logic            cout_valid, cout_ready;
  logic [RW-1:0]   cout_row;
  logic            ab_valid, ab_ready;
  logic [ML*XLEN-1:0] ab_a;
  logic [RW-1:0]   ab_b;
  logic            done, op_valid, a_valid, b_valid, c_valid;
  logic [AW-1:0]   op_addr, ab_addr, c_addr;
  logic [ML*XLEN-1:0] ai;
  logic [RW-1:0]   bi, ci, co;

  always #5 clk = ~clk;

  opacc_ctrl #(
    .NREGS(NREGS), .VL(VL), .ML(ML), .XLEN(XLEN), .KW(KW)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_k(cmd_k),
    .cin_valid(cin_valid), .cin_ready(cin_ready), .cin_row(cin_row),
    .cout_valid(cout_valid), .cout_ready(cout_ready), .cout_row(cout_row),
    .ab_valid(ab_valid), .ab_ready(ab_ready), .ab_a(ab_a), .ab_b(ab_b),
    .done(done), .op_valid(op_valid), .a_valid(a_valid), .b_valid(b_valid),
    .c_valid(c_valid), .op_addr(op_addr), .ab_addr(ab_addr), .c_addr(c_addr),
    .ai(ai), .bi(bi), .ci(ci), .co(co)
  );

  // Behavioural opacc: each tile is a row FIFO on swap (head row exits on co)
  // and accumulates a x b outer products using operands loaded a cycle earlier.
  logic [XLEN-1:0] tileM [NREGS][ML][VL];
  logic [XLEN-1:0] aReg  [NREGS][ML];
  logic [XLEN-1:0] bReg  [NREGS][VL];

  always @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NREGS; t++) begin
        for (int i = 0; i < ML; i++) begin
          aReg[t][i] <= '0;
          for (int j = 0; j < VL; j++) tileM[t][i][j] <= '0;
        end
        for (int j = 0; j < VL; j++) bReg[t][j] <= '0;
      end
    end else begin
      if (c_valid) begin
        for (int r = 0; r < ML - 1; r++)
          for (int j = 0; j < VL; j++) tileM[c_addr][r][j] <= tileM[c_addr][r+1][j];
        for (int j = 0; j < VL; j++) tileM[c_addr][ML-1][j] <= ci[j*XLEN +: XLEN];
      end
      if (a_valid)
        for (int i = 0; i < ML; i++) aReg[ab_addr][i] <= ai[i*XLEN +: XLEN];
      if (b_valid)
        for (int j = 0; j < VL; j++) bReg[ab_addr][j] <= bi[j*XLEN +: XLEN];
      if (op_valid)
        for (int i = 0; i < ML; i++)
          for (int j = 0; j < VL; j++)
            tileM[op_addr][i][j] <= tileM[op_addr][i][j] + aReg[op_addr][i] * bReg[op_addr][j];
    end
  end

  always_comb begin
    co = '0;
    for (int j = 0; j < VL; j++) co[j*XLEN +: XLEN] = tileM[c_addr][0][j];
  end

  typedef struct {
    int cyc;
    int ops;
    int accs;
  } done_exp_t;

  done_exp_t     expDone[$];
  logic [RW-1:0] expRows[$];
  logic [RW-1:0] inRows  [ML];
  logic [RW-1:0] outRows [ML];

  int nCompared  = 0;
  int nMismatched = 0;
  int cyc        = 0;
  int chkIdleCyc = -1;
  int tbTimeouts = 0;
  bit endCheck   = 1'b0;
  bit endDone    = 1'b0;
  bit busy       = 1'b0;
  bit prevA      = 1'b0;
  int opCnt      = 0;
  int accCnt     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RW-1:0] mkRow(input int base, input int step);
    logic [RW-1:0] r;
    r = '0;
    for (int j = 0; j < VL; j++) r[j*XLEN +: XLEN] = 64'(base + step * j);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: the only process that compares; it consumes the expectation
  // queues whenever the DUT presents a row or a done pulse.
  always @(negedge clk) begin
    done_exp_t e;
    if (reset) begin
      busy   = 1'b0;
      prevA  = 1'b0;
      opCnt  = 0;
      accCnt = 0;
    end else begin
      if (cyc == chkIdleCyc) begin
        checkOutput("idle_strobes", RW'({op_valid, a_valid, b_valid, c_valid, done, cout_valid, cin_ready, ab_ready}), '0);
        checkOutput("idle_cmd_ready", RW'(cmd_ready), RW'(1'b1));
        checkOutput("idle_addr", RW'({op_addr, ab_addr, c_addr}), '0);
      end
      if (busy) checkOutput("cmd_ready_busy", RW'(cmd_ready), '0);
      if (op_valid || prevA) checkOutput("op_after_load", RW'(op_valid), RW'(prevA));
      if (op_valid || c_valid) checkOutput("op_c_exclusive", RW'(op_valid & c_valid), '0);
      if (cin_valid && !cout_ready)
        checkOutput("stall_gate", RW'({c_valid, cin_ready, cout_valid}), '0);
      if (cout_valid && cout_ready) begin
        if (expRows.size() == 0) checkOutput("unexpected_row", RW'(1'b1), '0);
        else checkOutput("cout_row", cout_row, expRows.pop_front());
      end
      if (op_valid) opCnt++;
      if (a_valid) accCnt++;
      if (done) begin
        if (expDone.size() == 0) begin
          checkOutput("unexpected_done", RW'(1'b1), '0);
        end else begin
          e = expDone.pop_front();
          if (e.cyc >= 0) checkOutput("done_cycle", RW'(cyc), RW'(e.cyc));
          checkOutput("op_count", RW'(opCnt), RW'(e.ops));
          checkOutput("accept_count", RW'(accCnt), RW'(e.accs));
        end
        busy = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        busy   = 1'b1;
        opCnt  = 0;
        accCnt = 0;
      end
      prevA = a_valid;
    end
    if (endCheck && !endDone) begin
      checkOutput("rows_left", RW'(expRows.size()), '0);
      checkOutput("dones_left", RW'(expDone.size()), '0);
      checkOutput("timeouts", RW'(tbTimeouts), '0);
      endDone = 1'b1;
    end
  end

  task automatic applyStimulus(input logic op, input logic [AW-1:0] r, input int k, output int acceptCyc);
    bit got;
    got = 1'b0;
    acceptCyc = -1000;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = r;
    cmd_k     = KW'(k);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        acceptCyc = cyc;
        break;
      end
    end
    if (!got) tbTimeouts++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_reg   = ~r;
    cmd_k     = 16'hffff;
  endtask

  task automatic waitDone();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) tbTimeouts++;
    @(posedge clk); #1;
  endtask

  task automatic swapCmd(input logic [AW-1:0] r, input int stallBeat, input int stallLen, input int lat);
    int acc;
    bit got;
    for (int b = 0; b < ML; b++) expRows.push_back(outRows[b]);
    applyStimulus(1'b0, r, 0, acc);
    expDone.push_back('{cyc: (lat < 0) ? -1 : acc + lat, ops: 0, accs: 0});
    for (int b = 0; b < ML; b++) begin
      cin_valid = 1'b1;
      cin_row   = inRows[b];
      if (b == stallBeat) begin
        cout_ready = 1'b0;
        repeat (stallLen) begin
          @(posedge clk); #1;
        end
        cout_ready = 1'b1;
      end
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (cin_ready) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) tbTimeouts++;
      @(posedge clk); #1;
    end
    cin_valid = 1'b0;
    cin_row   = '0;
    waitDone();
  endtask

  task automatic macCmd(input logic [AW-1:0] r, input int k, input bit toggle, input int lat);
    int acc;
    int cnt;
    applyStimulus(1'b1, r, k, acc);
    expDone.push_back('{cyc: (lat < 0) ? -1 : acc + lat, ops: k, accs: k});
    cnt = 0;
    for (int t = 0; t < 200 && cnt < k; t++) begin
      ab_valid = toggle ? ((t % 2) == 0) : 1'b1;
      @(negedge clk);
      if (ab_valid && ab_ready) cnt++;
      @(posedge clk); #1;
    end
    ab_valid = 1'b0;
    if (cnt < k) tbTimeouts++;
    waitDone();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc;
    int cnt;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_reg = '0; cmd_k = '0;
    cin_valid = 1'b0; cin_row = '0; cout_ready = 1'b1;
    ab_valid = 1'b0; ab_a = '0; ab_b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chkIdleCyc = cyc;

    $display("[TB] test 1: back-to-back swaps on reg0");
    for (int b = 0; b < ML; b++) begin
      inRows[b]  = mkRow(16 * (b + 1), 1);
      outRows[b] = '0;
    end
    swapCmd(1'b0, -1, 0, 5);
    for (int b = 0; b < ML; b++) begin
      inRows[b]  = '0;
      outRows[b] = mkRow(16 * (b + 1), 1);
    end
    swapCmd(1'b0, -1, 0, 5);

    $display("[TB] test 2: MAC k=3 with a=b=2 on reg1");
    for (int b = 0; b < ML; b++) begin
      inRows[b]  = '0;
      outRows[b] = '0;
    end
    swapCmd(1'b1, -1, 0, 5);
    ab_a = {ML{64'd2}};
    ab_b = {VL{64'd2}};
    macCmd(1'b1, 3, 1'b0, 5);
    for (int b = 0; b < ML; b++) outRows[b] = {VL{64'd12}};
    swapCmd(1'b1, -1, 0, 5);

    $display("[TB] test 3/4: gapped MAC vs no-stall MAC, drained with a stall");
    ab_a = mkRow(1, 1);
    ab_b = mkRow(1, 1);
    macCmd(1'b0, 4, 1'b1, -1);
    macCmd(1'b1, 4, 1'b0, 6);
    for (int b = 0; b < ML; b++) begin
      inRows[b]  = '0;
      outRows[b] = mkRow(4 * (b + 1), 4 * (b + 1));
    end
    swapCmd(1'b0, 2, 5, 10);
    swapCmd(1'b1, -1, 0, 5);

    $display("[TB] test 5: MAC k=0");
    macCmd(1'b0, 0, 1'b0, 2);

    $display("[TB] test 6: reset mid-MAC");
    applyStimulus(1'b1, 1'b1, 4, acc);
    ab_valid = 1'b1;
    cnt = 0;
    for (int t = 0; t < 20 && cnt < 2; t++) begin
      @(negedge clk);
      if (ab_ready) cnt++;
      if (cnt < 2) begin
        @(posedge clk); #1;
      end
    end
    if (cnt < 2) tbTimeouts++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chkIdleCyc = cyc;
    @(negedge clk);
    @(posedge clk); #1;
    ab_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    endCheck = 1'b1;
    for (int t = 0; t < 10 && !endDone; t++) @(negedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
